multicycle_controller: RTL and testbench

Sequencing controller for the multicycle RV32I core. A Moore-style FSM steps the shared datapath (one ALU, one unified instruction/data memory port, IR/OldPC/A/WriteData/ALUOut/Data registers) through fetch, decode, execute, memory and writeback. It drives all datapath selects and write strobes, and instantiates the existing `alu_decoder` to produce `ALUControl`. It stalls on a memory-ready handshake and traps on unsupported opcodes.

---
 rtl/multicycle_controller.sv | 329 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Sequencing controller for the multicycle RV32I core. A Moore FSM steps the
//   shared datapath through fetch/decode/execute/memory/writeback, drives the
//   datapath selects and write strobes, and feeds alu_decoder for ALUControl.
//
// Ports
//   clk, reset                  core clock, async active-high reset
//   op, funct3, funct7          instruction fields from IR
//   Zero                        ALU zero flag (branch resolution)
//   mem_ready                   memory completes the current access this cycle
//   PCWrite, IRWrite, RegWrite,
//   MemWrite                    write strobes (forced low during reset)
//   AdrSrc, ResultSrc, ALUSrcA,
//   ALUSrcB                     datapath selects, decoded from state
//   ImmSrc                      immediate format, decoded from op
//   ALUControl, shift           from alu_decoder
//   instr_retired               pulse on the last cycle of each instruction
//   illegal_instr               sticky, set on entering TRAP

package multicycle_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_ITYPE  = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  typedef enum logic [2:0] {
    F3_ADD_BEQ = 3'b000,
    F3_SLL_BNE = 3'b001,
    F3_SLT     = 3'b010,
    F3_SLTU    = 3'b011,
    F3_XOR     = 3'b100,
    F3_SR      = 3'b101,
    F3_OR      = 3'b110,
    F3_AND     = 3'b111
  } funct3_e;

  typedef enum logic [6:0] {
    F7_BASE = 7'b0000000,
    F7_ALT  = 7'b0100000
  } funct7_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } aluop_e;

endpackage

// alu_decoder
//   Maps ALUOp (00 add, 01 sub, 10 funct-decoded) plus instruction fields to
//   an ALU operation. shift flags the three shift operations.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] alu_op,
  input  opcode_e    op,
  input  funct3_e    funct3,
  input  funct7_e    funct7,
  output aluop_e     alu_control,
  output logic       shift
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      2'b00: alu_control = ALU_ADD;
      2'b01: alu_control = ALU_SUB;
      2'b10: begin
        case (funct3)
          // funct7 only selects sub for register-register ops; addi has an
          // immediate in those bits
          F3_ADD_BEQ: alu_control = (op == OP_RTYPE && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL_BNE: alu_control = ALU_SLL;
          F3_SLT:     alu_control = ALU_SLT;
          F3_SLTU:    alu_control = ALU_SLTU;
          F3_XOR:     alu_control = ALU_XOR;
          F3_SR:      alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:      alu_control = ALU_OR;
          F3_AND:     alu_control = ALU_AND;
          default:    alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

  assign shift = (alu_control == ALU_SLL) || (alu_control == ALU_SRL) ||
                 (alu_control == ALU_SRA);

endmodule

// state      | meaning
// -----------+-----------------------------------------------------------
// S_FETCH    | read IR at PC, PC <= PC+4 when memory is ready
// S_DECODE   | ALUOut <= OldPC + imm (branch target), dispatch on op
// S_MEMADR   | ALUOut <= A + imm (load/store address)
// S_MEMREAD  | read memory at ALUOut, wait for mem_ready
// S_MEMWB    | rd <= Data
// S_MEMWRITE | write memory at ALUOut, held until mem_ready
// S_EXECR    | ALUOut <= A op WriteData
// S_EXECI    | ALUOut <= A op imm
// S_EXECLUI  | ALUOut <= 0 + imm
// S_ALUWB    | rd <= ALUOut
// S_BRANCH   | compare A/WriteData, PC <= target when taken
// S_JAL      | PC <= target, ALUOut <= OldPC + 4
// S_TRAP     | unsupported instruction, held until reset
module multicycle_controller
  import multicycle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  opcode_e    op,
  input  funct3_e    funct3,
  input  funct7_e    funct7,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ImmSrc,
  output aluop_e     ALUControl,
  output logic       shift,
  output logic       instr_retired,
  output logic       illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_EXECLUI, S_ALUWB, S_BRANCH, S_JAL, S_TRAP
  } state_e;

  state_e     state;
  logic [1:0] alu_op;
  logic       branch_legal;
  logic       branch_taken;
  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       retire_raw;

  assign branch_legal = (funct3 == F3_ADD_BEQ) || (funct3 == F3_SLL_BNE);
  assign branch_taken = (funct3 == F3_ADD_BEQ) ? Zero : ~Zero;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_FETCH;
      illegal_instr <= 1'b0;
    end else begin
      case (state)
        S_FETCH:
          if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: state <= S_MEMADR;
            OP_RTYPE:          state <= S_EXECR;
            OP_ITYPE:          state <= S_EXECI;
            OP_LUI:            state <= S_EXECLUI;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            default: begin
              state         <= S_TRAP;
              illegal_instr <= 1'b1;
            end
          endcase
        end
        S_MEMADR: begin
          if (op == OP_LOAD) begin
            state <= S_MEMREAD;
          end else if (op == OP_STORE) begin
            state <= S_MEMWRITE;
          end else begin
            // IR cannot change here; guards against a corrupted op only
            state         <= S_TRAP;
            illegal_instr <= 1'b1;
          end
        end
        S_MEMREAD:
          if (mem_ready) state <= S_MEMWB;
        S_MEMWB:
          state <= S_FETCH;
        S_MEMWRITE:
          if (mem_ready) state <= S_FETCH;
        S_EXECR, S_EXECI, S_EXECLUI:
          state <= S_ALUWB;
        S_ALUWB:
          state <= S_FETCH;
        S_BRANCH: begin
          if (branch_legal) begin
            state <= S_FETCH;
          end else begin
            state         <= S_TRAP;
            illegal_instr <= 1'b1;
          end
        end
        S_JAL:
          state <= S_ALUWB;
        S_TRAP:
          state <= S_TRAP;
        default:
          state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    retire_raw    = 1'b0;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    alu_op        = 2'b00;
    case (state)
      S_FETCH: begin
        ResultSrc    = 2'b10;
        ALUSrcB      = 2'b10;
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        retire_raw    = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_EXECLUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        retire_raw    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUSrcB      = 2'b00;
        alu_op       = 2'b01;
        pc_write_raw = branch_legal & branch_taken;
        retire_raw   = branch_legal;
      end
      S_JAL: begin
        ALUSrcA      = 2'b01;
        ALUSrcB      = 2'b10;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset itself so they drop the moment reset rises,
  // even mid-stall, rather than waiting for the state register.
  assign PCWrite       = pc_write_raw  & ~reset;
  assign IRWrite       = ir_write_raw  & ~reset;
  assign RegWrite      = reg_write_raw & ~reset;
  assign MemWrite      = mem_write_raw & ~reset;
  assign instr_retired = retire_raw    & ~reset;

  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
      OP_STORE:                   ImmSrc = 3'b001;
      OP_BRANCH:                  ImmSrc = 3'b010;
      OP_JAL:                     ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:           ImmSrc = 3'b100;
      default:                    ImmSrc = 3'b000;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .op          (op),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (ALUControl),
    .shift       (shift)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed instructions, each expanded by
// a behavioural model into the expected per-cycle control word, compared on
// every falling edge, plus literal checks on pulse counts, cycle counts and
// reset behaviour.
module tb_multicycle_controller;
  import multicycle_pkg::*;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  localparam int K_ADD = 0;
  localparam int K_SUB = 1;
  localparam int K_FN  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  opcode_e    op;
  funct3_e    funct3;
  funct7_e    funct7;
  logic       Zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ImmSrc;
  aluop_e     ALUControl;
  logic       shift, instr_retired, illegal_instr;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .shift(shift),
    .instr_retired(instr_retired), .illegal_instr(illegal_instr)
  );

  typedef struct packed {
    logic       pcw, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       sh, ret, ill;
  } ctrl_t;

  typedef struct {
    ctrl_t      c;
    logic       mr;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z;
  } step_t;

  step_t       steps[$];
  step_t       cur;
  bit          cur_valid = 0;
  int          step_idx;
  string       cur_name;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_ret, n_irw, n_pcw, n_rw;
  logic [6:0]  t_op, t_f7;
  logic [2:0]  t_f3;
  logic        t_z, t_ill;
  logic [20:0] got_v;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // RV32I ALU semantics for the current instruction
  function automatic logic [3:0] model_alu(input int kind);
    if (kind == K_ADD) return 4'(ALU_ADD);
    if (kind == K_SUB) return 4'(ALU_SUB);
    case (t_f3)
      3'd0: return (t_op == RTY && t_f7 == 7'h20) ? 4'(ALU_SUB) : 4'(ALU_ADD);
      3'd1: return 4'(ALU_SLL);
      3'd2: return 4'(ALU_SLT);
      3'd3: return 4'(ALU_SLTU);
      3'd4: return 4'(ALU_XOR);
      3'd5: return (t_f7 == 7'h20) ? 4'(ALU_SRA) : 4'(ALU_SRL);
      3'd6: return 4'(ALU_OR);
      default: return 4'(ALU_AND);
    endcase
  endfunction

  function automatic logic [2:0] model_imm(input logic [6:0] o);
    if (o == SW)  return 3'b001;
    if (o == BR)  return 3'b010;
    if (o == JAL) return 3'b011;
    if (o == LUI || o == 7'b0010111) return 3'b100;
    return 3'b000;
  endfunction

  task automatic push(input logic pcw, adr, mw, irw, rw,
                      input logic [1:0] rs, sa, sb, input int kind,
                      input logic ret, input logic mr);
    step_t s;
    s.c.pcw = pcw; s.c.adr = adr; s.c.mw = mw; s.c.irw = irw; s.c.rw = rw;
    s.c.rs = rs; s.c.sa = sa; s.c.sb = sb;
    s.c.imm = model_imm(t_op);
    s.c.alu = model_alu(kind);
    s.c.sh  = (s.c.alu == 4'(ALU_SLL)) || (s.c.alu == 4'(ALU_SRL)) ||
              (s.c.alu == 4'(ALU_SRA));
    s.c.ret = ret; s.c.ill = t_ill;
    s.mr = mr; s.op = t_op; s.f3 = t_f3; s.f7 = t_f7; s.z = t_z;
    steps.push_back(s);
  endtask

  task automatic trap_tail();
    t_ill = 1'b1;
    repeat (20) push(0,0,0,0,0,2'b00,2'b00,2'b00,K_ADD,0,1);
  endtask

  // Expected cycle-by-cycle control words for one instruction.
  // fw: fetch wait cycles, mwt: memory-phase wait cycles.
  task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input int fw, input int mwt);
    logic legal, taken;
    t_op = o; t_f3 = f3; t_f7 = f7; t_z = z; t_ill = 1'b0;
    steps.delete();
    repeat (fw) push(0,0,0,0,0,2'b10,2'b00,2'b10,K_ADD,0,0);
    push(1,0,0,1,0,2'b10,2'b00,2'b10,K_ADD,0,1);
    push(0,0,0,0,0,2'b00,2'b01,2'b01,K_ADD,0,1);
    case (o)
      LW: begin
        push(0,0,0,0,0,2'b00,2'b10,2'b01,K_ADD,0,1);
        repeat (mwt) push(0,1,0,0,0,2'b00,2'b00,2'b00,K_ADD,0,0);
        push(0,1,0,0,0,2'b00,2'b00,2'b00,K_ADD,0,1);
        push(0,0,0,0,1,2'b01,2'b00,2'b00,K_ADD,1,1);
      end
      SW: begin
        push(0,0,0,0,0,2'b00,2'b10,2'b01,K_ADD,0,1);
        repeat (mwt) push(0,1,1,0,0,2'b00,2'b00,2'b00,K_ADD,0,0);
        push(0,1,1,0,0,2'b00,2'b00,2'b00,K_ADD,1,1);
      end
      RTY, ITY, LUI: begin
        if (o == RTY)      push(0,0,0,0,0,2'b00,2'b10,2'b00,K_FN,0,1);
        else if (o == ITY) push(0,0,0,0,0,2'b00,2'b10,2'b01,K_FN,0,1);
        else               push(0,0,0,0,0,2'b00,2'b11,2'b01,K_ADD,0,1);
        push(0,0,0,0,1,2'b00,2'b00,2'b00,K_ADD,1,1);
      end
      BR: begin
        legal = (f3 == 3'd0) || (f3 == 3'd1);
        taken = legal && ((f3 == 3'd0) ? z : !z);
        push(taken,0,0,0,0,2'b00,2'b10,2'b00,K_SUB,legal,1);
        if (!legal) trap_tail();
      end
      JAL: begin
        push(1,0,0,0,0,2'b00,2'b01,2'b10,K_ADD,0,1);
        push(0,0,0,0,1,2'b00,2'b00,2'b00,K_ADD,1,1);
      end
      default: trap_tail();
    endcase
  endtask

  task automatic run(input string nm);
    n_ret = 0; n_irw = 0; n_pcw = 0; n_rw = 0;
    cur_name = nm;
    step_idx = 0;
    while (steps.size() > 0) begin
      @(posedge clk); #1;
      cur       = steps.pop_front();
      op        = opcode_e'(cur.op);
      funct3    = funct3_e'(cur.f3);
      funct7    = funct7_e'(cur.f7);
      Zero      = cur.z;
      mem_ready = cur.mr;
      cur_valid = 1;
      step_idx++;
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    cur_valid = 0;
  endtask

  always @(negedge clk) begin
    if (cur_valid) begin
      got_v = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, 4'(ALUControl), shift, instr_retired, illegal_instr};
      chk($sformatf("ctrl %s cycle %0d", cur_name, step_idx), 32'(got_v), 32'(cur.c));
      n_ret += int'(instr_retired);
      n_irw += int'(IRWrite);
      n_pcw += int'(PCWrite);
      n_rw  += int'(RegWrite);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    op = opcode_e'(RTY); funct3 = funct3_e'(3'd0); funct7 = funct7_e'(7'd0);
    Zero = 1'b0; mem_ready = 1'b1;
    #12;
    chk("reset IRWrite", 32'(IRWrite), 0);
    chk("reset PCWrite", 32'(PCWrite), 0);
    chk("reset RegWrite", 32'(RegWrite), 0);
    chk("reset MemWrite", 32'(MemWrite), 0);
    chk("reset retired", 32'(instr_retired), 0);
    chk("reset illegal", 32'(illegal_instr), 0);
    chk("reset fetch selects", 32'({AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}), 32'b0_00_10_10);
    mem_ready = 1'b0;
    #1 reset = 1'b0;

    build(RTY, 3'd0, 7'h00, 0, 0, 0);
    chk("add cycles", steps.size(), 4);
    run("add");
    chk("add retire pulses", n_ret, 1);
    chk("add regwrite pulses", n_rw, 1);

    build(LW, 3'd2, 7'h00, 0, 2, 1);
    chk("lw cycles", steps.size(), 8);
    run("lw_stall");
    chk("lw irwrite pulses", n_irw, 1);
    chk("lw retire pulses", n_ret, 1);

    build(SW, 3'd2, 7'h00, 0, 0, 1);
    chk("sw cycles", steps.size(), 5);
    run("sw_stall");
    chk("sw retire pulses", n_ret, 1);

    build(BR, 3'd0, 7'h00, 1, 0, 0);  run("beq_z1");  chk("beq z1 pcwrites", n_pcw, 2);
    build(BR, 3'd0, 7'h00, 0, 0, 0);  run("beq_z0");  chk("beq z0 pcwrites", n_pcw, 1);
    build(BR, 3'd1, 7'h00, 1, 0, 0);  run("bne_z1");  chk("bne z1 pcwrites", n_pcw, 1);
    build(BR, 3'd1, 7'h00, 0, 0, 0);  run("bne_z0");  chk("bne z0 pcwrites", n_pcw, 2);

    build(RTY, 3'd0, 7'h20, 0, 0, 0); run("sub");
    build(RTY, 3'd5, 7'h20, 0, 0, 0); run("sra");
    build(RTY, 3'd4, 7'h00, 0, 1, 0); run("xor");
    build(ITY, 3'd0, 7'h20, 0, 0, 0); run("addi");
    build(ITY, 3'd5, 7'h00, 0, 0, 0); run("srli");
    build(ITY, 3'd2, 7'h00, 0, 0, 0); run("slti");
    build(LUI, 3'd3, 7'h11, 0, 0, 0); run("lui");

    build(JAL, 3'd0, 7'h00, 0, 0, 0);
    chk("jal cycles", steps.size(), 4);
    run("jal");
    chk("jal pcwrites", n_pcw, 2);
    chk("jal regwrites", n_rw, 1);

    // reset while a store is stalled waiting for memory
    build(SW, 3'd2, 7'h00, 0, 0, 3);
    void'(steps.pop_back());
    run("sw_abort");
    chk("stalled MemWrite", 32'(MemWrite), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort MemWrite", 32'(MemWrite), 0);
    chk("abort RegWrite", 32'(RegWrite), 0);
    chk("abort PCWrite", 32'(PCWrite), 0);
    chk("abort retired", 32'(instr_retired), 0);
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("in reset IRWrite", 32'(IRWrite), 0);
    chk("in reset PCWrite", 32'(PCWrite), 0);
    mem_ready = 1'b0;
    #2 reset = 1'b0;
    @(negedge clk);
    chk("post abort fetch", 32'({AdrSrc, MemWrite, IRWrite, ALUSrcB, ResultSrc}), 32'b0_0_0_10_10);
    build(RTY, 3'd7, 7'h00, 0, 0, 0); run("and_after_abort");
    chk("and retire pulses", n_ret, 1);

    build(JALR, 3'd0, 7'h00, 0, 0, 0);
    chk("jalr cycles", steps.size(), 22);
    run("jalr_trap");
    chk("jalr illegal held", 32'(illegal_instr), 1);
    chk("jalr retire pulses", n_ret, 0);
    reset = 1'b1;
    #2;
    chk("reset clears illegal", 32'(illegal_instr), 0);
    #1 reset = 1'b0;

    build(BR, 3'd4, 7'h00, 1, 0, 0);
    run("blt_trap");
    chk("blt pcwrites", n_pcw, 1);
    chk("blt illegal", 32'(illegal_instr), 1);
    reset = 1'b1;
    #2;
    chk("reset clears illegal 2", 32'(illegal_instr), 0);
    #1 reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
